mem_issue_queue: RTL and testbench

Warp-level memory request queue that sits directly upstream of the memory controller. It buffers strided memory instructions from the execution pipeline and expands each one into per-thread addresses (base + i·stride). It presents one request at a time using the controller's hold-valid protocol: valid held two cycles, then released so the controller can leave coalescing. It returns read data to the issuing warp when the controller goes idle again.

---
 rtl/mem_issue_queue_if.sv | 43 ++++
 rtl/mem_issue_queue.sv | 196 +++++++++++++++++++
 tb/tb_mem_issue_queue.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_issue_queue_if.sv
// Handshake bundle between the execution pipeline, the memory issue queue and
// the memory controller. The queue uses the slave view, its environment the master view.
interface mem_issue_queue_if #(
  parameter int THREADS_PER_WARP = 32
);
  logic                             in_valid;
  logic                             in_ready;
  logic [31:0]                      in_base_addr;
  logic [31:0]                      in_stride;
  logic [THREADS_PER_WARP-1:0][31:0] in_write_data;
  logic [31:0]                      in_thread_mask;
  logic                             in_write_en;
  logic [5:0]                       in_warp_id;

  logic [THREADS_PER_WARP-1:0][31:0] exec_address;
  logic [THREADS_PER_WARP-1:0][31:0] exec_write_data;
  logic [31:0]                      exec_thread_mask;
  logic                             exec_write_en;
  logic [5:0]                       exec_warp_id;
  logic                             exec_request_valid;
  logic                             exec_ready;
  logic [THREADS_PER_WARP-1:0][31:0] exec_read_data;

  logic                             rsp_valid;
  logic [5:0]                       rsp_warp_id;
  logic [THREADS_PER_WARP-1:0][31:0] rsp_data;

  modport slave (
    input  in_valid, in_base_addr, in_stride, in_write_data, in_thread_mask,
           in_write_en, in_warp_id, exec_ready, exec_read_data,
    output in_ready, exec_address, exec_write_data, exec_thread_mask,
           exec_write_en, exec_warp_id, exec_request_valid,
           rsp_valid, rsp_warp_id, rsp_data
  );

  modport master (
    output in_valid, in_base_addr, in_stride, in_write_data, in_thread_mask,
           in_write_en, in_warp_id, exec_ready, exec_read_data,
    input  in_ready, exec_address, exec_write_data, exec_thread_mask,
           exec_write_en, exec_warp_id, exec_request_valid,
           rsp_valid, rsp_warp_id, rsp_data
  );
endinterface

// File: rtl/mem_issue_queue.sv
// Warp memory request queue: buffers strided requests, expands per-lane addresses and
// issues them with the controller's hold-valid protocol. Optional counters: MEM_ISSUE_STATS_EN.
module mem_issue_queue #(
  parameter int DEPTH            = 4,
  parameter int THREADS_PER_WARP = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_issue_queue_if.slave  bus
`ifdef MEM_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [THREADS_PER_WARP-1:0][31:0] lane_vec_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] stride;
    lane_vec_t   write_data;
    logic [31:0] thread_mask;
    logic        write_en;
    logic [5:0]  warp_id;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             issue;
  state_t           state;
  state_t           state_next;
  lane_vec_t        addr_next;

  lane_vec_t        addr_q;
  lane_vec_t        wdata_q;
  logic [31:0]      mask_q;
  logic             we_q;
  logic [5:0]       warp_q;
  logic             rsp_valid_q;
  logic [5:0]       rsp_warp_q;
  lane_vec_t        rsp_data_q;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Zero-mask requests complete the handshake but never occupy a slot.
  assign push = bus.in_valid && !full && (bus.in_thread_mask != '0);

  assign in_entry = '{
    base_addr:   bus.in_base_addr,
    stride:      bus.in_stride,
    write_data:  bus.in_write_data,
    thread_mask: bus.in_thread_mask,
    write_en:    bus.in_write_en,
    warp_id:     bus.in_warp_id
  };

  assign head = mem[rd_ptr];

  // NOTE: payload storage has no reset; validity is tracked solely by count/pointers,
  // so clearing it would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    pop        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty && bus.exec_ready) begin
          issue      = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE:     state_next = S_HOLD;
      S_HOLD:      state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.exec_ready) state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.exec_ready) begin
          pop        = 1'b1;
          state_next = S_IDLE;
        end
      end
      default:     state_next = S_IDLE;
    endcase
  end

  // Address expansion wraps mod 2^32; masked lanes are computed as well.
  always_comb begin
    addr_next = '0;
    for (int i = 0; i < THREADS_PER_WARP; i++) begin
      addr_next[i] = head.base_addr + head.stride * 32'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      warp_q  <= '0;
    end else if (issue) begin
      addr_q  <= addr_next;
      wdata_q <= head.write_data;
      mask_q  <= head.thread_mask;
      we_q    <= head.write_en;
      warp_q  <= head.warp_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_warp_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= pop && !we_q;
      if (pop && !we_q) begin
        rsp_warp_q <= warp_q;
        rsp_data_q <= bus.exec_read_data;
      end
    end
  end

  assign bus.in_ready           = !full;
  assign bus.exec_request_valid = (state == S_ISSUE) || (state == S_HOLD);
  assign bus.exec_address       = addr_q;
  assign bus.exec_write_data    = wdata_q;
  assign bus.exec_thread_mask   = mask_q;
  assign bus.exec_write_en      = we_q;
  assign bus.exec_warp_id       = warp_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_warp_id        = rsp_warp_q;
  assign bus.rsp_data           = rsp_data_q;

`ifdef MEM_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued      <= '0;
      stat_full_cycles <= '0;
    end else begin
      if (issue && (stat_issued != '1))
        stat_issued <= stat_issued + 32'd1;
      if (bus.in_valid && full && (stat_full_cycles != '1))
        stat_full_cycles <= stat_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: directed steps plus random requests, checked against a
// queue-level model and a small memory-controller responder.
module tb_mem_issue_queue;

  localparam int T     = 32;
  localparam int DEPTH = 4;

  typedef logic [T-1:0][31:0] lane_vec_t;

  typedef struct {
    logic [5:0]  warp;
    logic [31:0] base;
    logic [31:0] stride;
    logic [31:0] mask;
    logic        we;
    lane_vec_t   wdata;
  } req_t;

  typedef struct {
    logic [5:0] warp;
    lane_vec_t  data;
    int         due;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  mem_issue_queue_if #(.THREADS_PER_WARP(T)) bus ();

`ifdef MEM_ISSUE_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_full_cycles;
  int          full_cyc_model;
`endif

  mem_issue_queue #(.DEPTH(DEPTH), .THREADS_PER_WARP(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ISSUE_STATS_EN
    ,
    .stat_issued      (stat_issued),
    .stat_full_cycles (stat_full_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

`ifdef MEM_ISSUE_STATS_EN
  always @(posedge clk) begin
    if (!rst_n) full_cyc_model <= 0;
    else if (bus.in_valid && !bus.in_ready) full_cyc_model <= full_cyc_model + 1;
  end
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model state shared by the stimulus and the controller responder.
  req_t       exp_q[$];
  rsp_t       exp_rsp[$];
  logic [5:0] issued_log[$];
  int         model_count = 0;
  req_t       cur;
  bit         inflight = 0;
  bit         pop_pending = 0;
  bit         hold_ready = 0;
  bit         rand_busy = 0;
  int         busy_len = 2;
  bit         use_fixed = 0;
  logic [31:0] fixed_rd0 = '0;
  bit         busy = 0;
  int         busy_left = 0;
  bit         prev_valid = 0;
  int         run = 0;
  int         issue_count = 0;
  int         issues_since_reset = 0;
  int         issue_cyc = 0;
  int         last_issue_cyc = -1;
  int         pop_cyc = 0;
  int         rsp_count = 0;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  function automatic lane_vec_t rand_lanes();
    lane_vec_t v;
    for (int i = 0; i < T; i++) v[i] = $urandom;
    return v;
  endfunction

  // Memory-controller responder and output monitor; samples 1 time unit after each edge.
  initial begin : responder
    bus.exec_ready     = 1'b1;
    bus.exec_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        exp_rsp.delete();
        model_count = 0;
        inflight = 0;
        pop_pending = 0;
        busy = 0;
        prev_valid = 0;
        run = 0;
        last_issue_cyc = -1;
        issues_since_reset = 0;
        bus.exec_ready = 1'b1;
        continue;
      end

      if (pop_pending) begin
        model_count--;
        pop_pending = 0;
        inflight = 0;
        pop_cyc = cyc;
      end

      begin : rsp_side
        bit due;
        int nbad;
        due = (exp_rsp.size() != 0) && (exp_rsp[0].due == cyc);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(due));
        if (bus.rsp_valid) rsp_count++;
        if (due) begin
          nbad = 0;
          for (int i = 0; i < T; i++) if (bus.rsp_data[i] !== exp_rsp[0].data[i]) nbad++;
          check("rsp_warp_id", 32'(bus.rsp_warp_id), 32'(exp_rsp[0].warp));
          check("rsp_data_bad_lanes", 32'(nbad), 32'd0);
          void'(exp_rsp.pop_front());
        end
      end

      begin : issue_side
        bit v;
        bit fell;
        int blen;
        lane_vec_t rd;
        v = bus.exec_request_valid;
        if (v && !prev_valid) begin
          issue_count++;
          issues_since_reset++;
          run = 1;
          check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            inflight = 1;
            issue_cyc = cyc;
            issued_log.push_back(cur.warp);
            if (last_issue_cyc >= 0)
              check("issue_spacing_ge5", 32'((cyc - last_issue_cyc) >= 5), 32'd1);
            last_issue_cyc = cyc;
            check("exec_warp_id", 32'(bus.exec_warp_id), 32'(cur.warp));
            check("exec_thread_mask", bus.exec_thread_mask, cur.mask);
            check("exec_write_en", 32'(bus.exec_write_en), 32'(cur.we));
            for (int i = 0; i < T; i++) begin
              check("exec_address", bus.exec_address[i], cur.base + cur.stride * 32'(i));
              check("exec_write_data", bus.exec_write_data[i], cur.wdata[i]);
            end
          end
        end else if (v) begin
          run++;
        end
        fell = !v && prev_valid;
        if (fell) begin
          check("valid_cycles", 32'(run), 32'd2);
          check("payload_stable_warp", 32'(bus.exec_warp_id), 32'(cur.warp));
          check("payload_stable_addr31", bus.exec_address[T-1], cur.base + cur.stride * 32'(T-1));
        end
        prev_valid = v;

        if (hold_ready) begin
          bus.exec_ready = 1'b0;
        end else if (fell) begin
          blen = rand_busy ? int'($urandom_range(4, 1)) : busy_len;
          bus.exec_ready = 1'b0;
          busy_left = blen - 1;
          busy = 1;
        end else if (busy) begin
          if (busy_left == 0) begin
            rd = rand_lanes();
            if (use_fixed) rd[0] = fixed_rd0;
            bus.exec_read_data = rd;
            bus.exec_ready = 1'b1;
            busy = 0;
            pop_pending = 1;
            if (!cur.we) exp_rsp.push_back('{warp: cur.warp, data: rd, due: cyc + 1});
          end else begin
            busy_left--;
          end
        end else begin
          bus.exec_ready = 1'b1;
        end
      end
    end
  end

  task automatic push(input logic [5:0] warp, input logic [31:0] base, input logic [31:0] stride,
                      input logic [31:0] mask, input logic we, input lane_vec_t wdata,
                      output int acc_cyc);
    int n;
    req_t r;
    bus.in_valid       = 1'b1;
    bus.in_warp_id     = warp;
    bus.in_base_addr   = base;
    bus.in_stride      = stride;
    bus.in_thread_mask = mask;
    bus.in_write_en    = we;
    bus.in_write_data  = wdata;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(model_count < DEPTH));
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      #1;
      check("in_ready", 32'(bus.in_ready), 32'(model_count < DEPTH));
      n++;
    end
    check("push_accepted", 32'(bus.in_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    if (mask != '0) begin
      r = '{warp: warp, base: base, stride: stride, mask: mask, we: we, wdata: wdata};
      exp_q.push_back(r);
      model_count++;
    end
  endtask

  task automatic wait_issue(input int n0);
    int k;
    k = 0;
    while (issue_count == n0 && k < 200) begin
      tick();
      k++;
    end
    check("issue_seen", 32'(issue_count != n0), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    bit idle;
    k = 0;
    idle = 0;
    while (k < limit) begin
      tick();
      idle = (exp_q.size() == 0) && !inflight && !busy && !pop_pending &&
             (exp_rsp.size() == 0) && (model_count == 0);
      if (idle) break;
      k++;
    end
    check("idle_reached", 32'(idle), 32'd1);
  endtask

  initial begin : stimulus
    int acc;
    int n0;
    int r0;
    int base_idx;
    logic [31:0] m;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_base_addr = '0;
    bus.in_stride = '0;
    bus.in_write_data = '0;
    bus.in_thread_mask = '0;
    bus.in_write_en = 1'b0;
    bus.in_warp_id = '0;

    // Reset state
    #12;
    check("rst_exec_request_valid", 32'(bus.exec_request_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_exec_warp_id", 32'(bus.exec_warp_id), 32'd0);
    check("rst_exec_address0", bus.exec_address[0], 32'd0);
    check("rst_exec_thread_mask", bus.exec_thread_mask, 32'd0);
    check("rst_rsp_warp_id", 32'(bus.rsp_warp_id), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Address expansion and issue latency
    n0 = issue_count;
    push(6'd1, 32'h0000_1000, 32'd4, 32'hFFFF_FFFF, 1'b0, rand_lanes(), acc);
    wait_issue(n0);
    check("issue_latency", 32'(issue_cyc - acc), 32'd1);
    check("addr_lane0", bus.exec_address[0], 32'h0000_1000);
    check("addr_lane31", bus.exec_address[31], 32'h0000_107C);
    check("valid_first", 32'(bus.exec_request_valid), 32'd1);
    tick();
    check("valid_second", 32'(bus.exec_request_valid), 32'd1);
    tick();
    check("valid_released", 32'(bus.exec_request_valid), 32'd0);
    wait_idle(200);

    // Wrap-around with a negative stride
    n0 = issue_count;
    push(6'd2, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 1'b1, rand_lanes(), acc);
    wait_issue(n0);
    check("wrap_lane2", bus.exec_address[2], 32'h0000_0000);
    check("wrap_lane3", bus.exec_address[3], 32'hFFFF_FFFC);
    wait_idle(200);

    // Load return after a 3-cycle busy window, then the same for a store
    busy_len = 3;
    use_fixed = 1;
    fixed_rd0 = 32'hDEAD_BEEF;
    r0 = rsp_count;
    push(6'd5, 32'h0000_2000, 32'd8, 32'hFFFF_FFFF, 1'b0, rand_lanes(), acc);
    n0 = 0;
    while (!bus.rsp_valid && n0 < 200) begin
      tick();
      n0++;
    end
    check("load_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    check("load_rsp_warp", 32'(bus.rsp_warp_id), 32'd5);
    check("load_rsp_lane0", bus.rsp_data[0], 32'hDEAD_BEEF);
    tick();
    check("load_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    wait_idle(200);
    check("load_rsp_count", 32'(rsp_count - r0), 32'd1);
    r0 = rsp_count;
    push(6'd5, 32'h0000_2000, 32'd8, 32'hFFFF_FFFF, 1'b1, rand_lanes(), acc);
    wait_idle(200);
    repeat (3) tick();
    check("store_no_rsp", 32'(rsp_count - r0), 32'd0);
    use_fixed = 0;
    busy_len = 2;

    // Full queue and backpressure
    hold_ready = 1;
    tick();
    for (int w = 20; w < 24; w++)
      push(6'(w), 32'h100 * 32'(w), 32'd4, 32'hFFFF_FFFF, 1'(w & 1), rand_lanes(), acc);
    bus.in_valid = 1'b1;
    bus.in_warp_id = 6'd24;
    repeat (3) begin
      #1;
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    hold_ready = 0;
    push(6'd24, 32'h0000_1800, 32'd4, 32'hFFFF_FFFF, 1'b0, rand_lanes(), acc);
    check("fifth_accept_after_pop", 32'(acc - pop_cyc), 32'd1);
    wait_idle(400);
    base_idx = issued_log.size() - 5;
    for (int k = 0; k < 5; k++)
      check("drain_order", 32'(issued_log[base_idx + k]), 32'(20 + k));

    // Zero-mask request is accepted but never issued
    n0 = issued_log.size();
    push(6'd10, 32'h0000_3000, 32'd4, 32'h0000_00FF, 1'b0, rand_lanes(), acc);
    push(6'd11, 32'h0000_4000, 32'd4, 32'h0000_0000, 1'b0, rand_lanes(), acc);
    push(6'd12, 32'h0000_5000, 32'd4, 32'hFF00_0000, 1'b1, rand_lanes(), acc);
    wait_idle(400);
    check("zero_mask_issue_count", 32'(issued_log.size() - n0), 32'd2);
    check("zero_mask_first", 32'(issued_log[n0]), 32'd10);
    check("zero_mask_second", 32'(issued_log[n0 + 1]), 32'd12);

    // Reset in the middle of HOLD
    n0 = issue_count;
    push(6'd30, 32'h0000_6000, 32'd4, 32'hFFFF_FFFF, 1'b0, rand_lanes(), acc);
    wait_issue(n0);
    tick();
    check("hold_valid", 32'(bus.exec_request_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_exec_request_valid", 32'(bus.exec_request_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n0 = issue_count;
    push(6'd31, 32'h0000_7000, 32'd16, 32'hFFFF_FFFF, 1'b0, rand_lanes(), acc);
    wait_idle(200);
    check("post_reset_issues", 32'(issue_count - n0), 32'd1);
    check("post_reset_warp", 32'(issued_log[issued_log.size() - 1]), 32'd31);

    // Randomised traffic
    rand_busy = 1;
    repeat (40) begin
      repeat ($urandom_range(3, 0)) tick();
      m = ($urandom_range(7, 0) == 0) ? 32'd0 : 32'($urandom);
      push(6'($urandom), 32'($urandom), 32'($urandom), m, 1'($urandom), rand_lanes(), acc);
    end
    wait_idle(2000);
    check("model_queue_empty", 32'(exp_q.size()), 32'd0);
    check("model_rsp_empty", 32'(exp_rsp.size()), 32'd0);

`ifdef MEM_ISSUE_STATS_EN
    check("stat_issued", stat_issued, 32'(issues_since_reset));
    check("stat_full_cycles", stat_full_cycles, 32'(full_cyc_model));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
